// File: rtl/core_bus_arbiter.sv
// Two-master (fetch/data) arbiter onto a single-beat memory port.
// Data bus has priority unless the fetch side has been starved STARVE_LIMIT times in a row.
module core_bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  output logic        iresp_addr_ok,
  output logic        iresp_data_ok,
  output logic [31:0] iresp_data,
  input  logic        dreq_valid,
  input  logic [63:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_strobe,
  input  logic [63:0] dreq_data,
  output logic        dresp_addr_ok,
  output logic        dresp_data_ok,
  output logic [63:0] dresp_data,
  output logic        mem_valid,
  output logic        mem_is_write,
  output logic [63:0] mem_addr,
  output logic [2:0]  mem_size,
  output logic [7:0]  mem_strobe,
  output logic [63:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [63:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] starveCnt_q, starveCnt_d;
  logic [63:0]   addr_q, addr_d;
  logic [2:0]    size_q, size_d;
  logic [7:0]    strobe_q, strobe_d;
  logic [63:0]   wdata_q, wdata_d;
  logic          grantI, grantD;

  // Fetch only overrides a competing data request once the starvation limit is hit
  always_comb begin
    grantI = 1'b0;
    grantD = 1'b0;
    if (state_q == IDLE) begin
      if (dreq_valid && !(ireq_valid && starveCnt_q == LIMIT)) begin
        grantD = 1'b1;
      end else if (ireq_valid) begin
        grantI = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grantD)      state_d = BUSY_D;
        else if (grantI) state_d = BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request fields are captured on the grant edge so the requester may drop valid right after addr_ok
  always_comb begin
    addr_d      = addr_q;
    size_d      = size_q;
    strobe_d    = strobe_q;
    wdata_d     = wdata_q;
    starveCnt_d = starveCnt_q;
    if (grantD) begin
      addr_d   = dreq_addr;
      size_d   = dreq_size;
      strobe_d = dreq_strobe;
      wdata_d  = dreq_data;
      if (!ireq_valid)                starveCnt_d = '0;
      else if (starveCnt_q != LIMIT)  starveCnt_d = starveCnt_q + 1'b1;
    end else if (grantI) begin
      addr_d      = ireq_addr;
      size_d      = 3'b010;
      strobe_d    = 8'h00;
      wdata_d     = 64'h0;
      starveCnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starveCnt_q <= '0;
      addr_q      <= 64'h0;
      size_q      <= 3'b000;
      strobe_q    <= 8'h00;
      wdata_q     <= 64'h0;
    end else begin
      starveCnt_q <= starveCnt_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      strobe_q    <= strobe_d;
      wdata_q     <= wdata_d;
    end
  end

  // addr_ok is gated by reset because the grant logic itself is purely combinational
  always_comb begin
    iresp_addr_ok = reset & grantI;
    dresp_addr_ok = reset & grantD;
    iresp_data_ok = (state_q == BUSY_I) && mem_ready;
    dresp_data_ok = (state_q == BUSY_D) && mem_ready;
    iresp_data    = 32'h0;
    dresp_data    = 64'h0;
    if (iresp_data_ok) iresp_data = addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
    if (dresp_data_ok) dresp_data = mem_rdata;
    mem_valid    = (state_q != IDLE);
    mem_is_write = |strobe_q;
    mem_addr     = addr_q;
    mem_size     = size_q;
    mem_strobe   = strobe_q;
    mem_wdata    = wdata_q;
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed bench for core_bus_arbiter: a per-cycle vector table plus hand sequences
// for starvation and asynchronous reset during a transaction.
module tb_core_bus_arbiter;

  localparam logic [63:0] A_I  = 64'h0000_0000_8000_0004;
  localparam logic [63:0] A_I2 = 64'h0000_0000_8000_0000;
  localparam logic [63:0] A_D  = 64'h0000_0000_8000_1000;
  localparam logic [63:0] R1   = 64'h1111_2222_3333_4444;
  localparam logic [63:0] R2   = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] R3   = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] WD   = 64'h0000_0000_0000_DEAD;

  logic        clk, reset;
  logic        ireqValid, iAddrOk, iDataOk;
  logic [63:0] ireqAddr;
  logic [31:0] iData;
  logic        dreqValid, dAddrOk, dDataOk;
  logic [63:0] dreqAddr, dreqData, dData;
  logic [2:0]  dreqSize, memSize;
  logic [7:0]  dreqStrobe, memStrobe;
  logic        memValid, memIsWrite, memReady;
  logic [63:0] memAddr, memWdata, memRdata;

  int checks = 0;
  int errors = 0;

  core_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireqValid), .ireq_addr(ireqAddr),
    .iresp_addr_ok(iAddrOk), .iresp_data_ok(iDataOk), .iresp_data(iData),
    .dreq_valid(dreqValid), .dreq_addr(dreqAddr), .dreq_size(dreqSize),
    .dreq_strobe(dreqStrobe), .dreq_data(dreqData),
    .dresp_addr_ok(dAddrOk), .dresp_data_ok(dDataOk), .dresp_data(dData),
    .mem_valid(memValid), .mem_is_write(memIsWrite), .mem_addr(memAddr),
    .mem_size(memSize), .mem_strobe(memStrobe), .mem_wdata(memWdata),
    .mem_ready(memReady), .mem_rdata(memRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [63:0] ia;
    logic        dv;
    logic [63:0] da;
    logic [2:0]  ds;
    logic [7:0]  dst;
    logic [63:0] dd;
    logic        rdy;
    logic [63:0] rd;
    logic        eIAok;
    logic        eIDok;
    logic [31:0] eIData;
    logic        eDAok;
    logic        eDDok;
    logic [63:0] eDData;
    logic        eMv;
    logic        eMw;
    logic [63:0] eMa;
    logic [2:0]  eMs;
    logic [7:0]  eMst;
    logic [63:0] eMwd;
  } vector_t;

  vector_t vecs [11];

  // Drives one cycle's worth of inputs
  task automatic applyStimulus(input vector_t v);
    reset      = v.rst;
    ireqValid  = v.iv;
    ireqAddr   = v.ia;
    dreqValid  = v.dv;
    dreqAddr   = v.da;
    dreqSize   = v.ds;
    dreqStrobe = v.dst;
    dreqData   = v.dd;
    memReady   = v.rdy;
    memRdata   = v.rd;
  endtask

  task automatic setInputs(input logic iv, input logic [63:0] ia, input logic dv,
                           input logic [7:0] dst, input logic rdy, input logic [63:0] rd);
    ireqValid  = iv;
    ireqAddr   = ia;
    dreqValid  = dv;
    dreqAddr   = A_D;
    dreqSize   = 3'd3;
    dreqStrobe = dst;
    dreqData   = WD;
    memReady   = rdy;
    memRdata   = rd;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkVector(input int i, input vector_t v);
    checkOutput($sformatf("v%0d iresp_addr_ok", i), 64'(iAddrOk), 64'(v.eIAok));
    checkOutput($sformatf("v%0d iresp_data_ok", i), 64'(iDataOk), 64'(v.eIDok));
    checkOutput($sformatf("v%0d iresp_data", i),    64'(iData),   64'(v.eIData));
    checkOutput($sformatf("v%0d dresp_addr_ok", i), 64'(dAddrOk), 64'(v.eDAok));
    checkOutput($sformatf("v%0d dresp_data_ok", i), 64'(dDataOk), 64'(v.eDDok));
    checkOutput($sformatf("v%0d dresp_data", i),    dData,        v.eDData);
    checkOutput($sformatf("v%0d mem_valid", i),     64'(memValid),   64'(v.eMv));
    checkOutput($sformatf("v%0d mem_is_write", i),  64'(memIsWrite), 64'(v.eMw));
    checkOutput($sformatf("v%0d mem_addr", i),      memAddr,         v.eMa);
    checkOutput($sformatf("v%0d mem_size", i),      64'(memSize),    64'(v.eMs));
    checkOutput($sformatf("v%0d mem_strobe", i),    64'(memStrobe),  64'(v.eMst));
    checkOutput($sformatf("v%0d mem_wdata", i),     memWdata,        v.eMwd);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // One data-bus read: grant cycle then completion cycle with mem_ready
  task automatic dTransaction(input logic iHigh, input string tag);
    setInputs(iHigh, A_I, 1'b1, 8'h00, 1'b0, 64'h0);
    @(negedge clk);
    checkOutput({tag, " dresp_addr_ok"}, 64'(dAddrOk), 64'd1);
    checkOutput({tag, " iresp_addr_ok"}, 64'(iAddrOk), 64'd0);
    nextCycle();
    setInputs(iHigh, A_I, 1'b0, 8'h00, 1'b1, R2);
    @(negedge clk);
    checkOutput({tag, " dresp_data_ok"}, 64'(dDataOk), 64'd1);
    checkOutput({tag, " dresp_data"},    dData, R2);
    checkOutput({tag, " busy iresp_addr_ok"}, 64'(iAddrOk), 64'd0);
    nextCycle();
  endtask

  task automatic iGrantAndComplete(input string tag);
    setInputs(1'b1, A_I, 1'b1, 8'h00, 1'b0, 64'h0);
    @(negedge clk);
    checkOutput({tag, " iresp_addr_ok"}, 64'(iAddrOk), 64'd1);
    checkOutput({tag, " dresp_addr_ok"}, 64'(dAddrOk), 64'd0);
    nextCycle();
    setInputs(1'b0, 64'h0, 1'b0, 8'h00, 1'b1, R1);
    @(negedge clk);
    checkOutput({tag, " iresp_data_ok"}, 64'(iDataOk), 64'd1);
    checkOutput({tag, " iresp_data"},    64'(iData), 64'h1111_2222);
    nextCycle();
  endtask

  initial begin
    //           rst iv ia    dv da   ds    dst    dd  rdy rd    | IAok IDok IData          DAok DDok DData  Mv Mw Ma    Ms    Mst    Mwd
    vecs[0]  = '{0, 1, A_I,  1, A_D, 3'd3, 8'hFF, WD, 1, R1,     0, 0, 32'h0,           0, 0, 64'h0, 0, 0, 64'h0, 3'd0, 8'h00, 64'h0};
    vecs[1]  = '{1, 1, A_I,  0, 0,   3'd0, 8'h00, 0,  0, 0,      1, 0, 32'h0,           0, 0, 64'h0, 0, 0, 64'h0, 3'd0, 8'h00, 64'h0};
    vecs[2]  = '{1, 0, 0,    0, 0,   3'd0, 8'h00, 0,  0, 0,      0, 0, 32'h0,           0, 0, 64'h0, 1, 0, A_I,   3'd2, 8'h00, 64'h0};
    vecs[3]  = '{1, 0, 0,    0, 0,   3'd0, 8'h00, 0,  0, 0,      0, 0, 32'h0,           0, 0, 64'h0, 1, 0, A_I,   3'd2, 8'h00, 64'h0};
    vecs[4]  = '{1, 0, 0,    0, 0,   3'd0, 8'h00, 0,  1, R1,     0, 1, 32'h1111_2222,   0, 0, 64'h0, 1, 0, A_I,   3'd2, 8'h00, 64'h0};
    vecs[5]  = '{1, 0, 0,    0, 0,   3'd0, 8'h00, 0,  1, R2,     0, 0, 32'h0,           0, 0, 64'h0, 0, 0, A_I,   3'd2, 8'h00, 64'h0};
    vecs[6]  = '{1, 1, A_I2, 1, A_D, 3'd3, 8'hFF, WD, 0, 0,      0, 0, 32'h0,           1, 0, 64'h0, 0, 0, A_I,   3'd2, 8'h00, 64'h0};
    vecs[7]  = '{1, 1, A_I2, 0, 0,   3'd0, 8'h00, 0,  1, R2,     0, 0, 32'h0,           0, 1, R2,    1, 1, A_D,   3'd3, 8'hFF, WD};
    vecs[8]  = '{1, 1, A_I2, 0, 0,   3'd0, 8'h00, 0,  0, 0,      1, 0, 32'h0,           0, 0, 64'h0, 0, 1, A_D,   3'd3, 8'hFF, WD};
    vecs[9]  = '{1, 0, 0,    0, 0,   3'd0, 8'h00, 0,  1, R3,     0, 1, 32'hCCCC_DDDD,   0, 0, 64'h0, 1, 0, A_I2,  3'd2, 8'h00, 64'h0};
    vecs[10] = '{1, 0, 0,    0, 0,   3'd0, 8'h00, 0,  0, 0,      0, 0, 32'h0,           0, 0, 64'h0, 0, 0, A_I2,  3'd2, 8'h00, 64'h0};

    applyStimulus(vecs[0]);
    nextCycle();
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkVector(i, vecs[i]);
      nextCycle();
    end

    // Starvation: four data grants while fetch waits, then fetch wins
    for (int g = 0; g < 4; g++) dTransaction(1'b1, $sformatf("starve d%0d", g));
    iGrantAndComplete("starve ibus");
    // Counter cleared by the fetch grant: data wins again
    dTransaction(1'b1, "post-starve d");
    dTransaction(1'b1, "partial d1");
    // Data grant with fetch idle clears the count, so four more data grants precede fetch
    dTransaction(1'b0, "clear d");
    for (int g = 0; g < 4; g++) dTransaction(1'b1, $sformatf("restarve d%0d", g));
    iGrantAndComplete("restarve ibus");

    // Asynchronous reset while a write awaits mem_ready
    setInputs(1'b0, 64'h0, 1'b1, 8'hFF, 1'b0, 64'h0);
    @(negedge clk);
    checkOutput("rst-mid dresp_addr_ok", 64'(dAddrOk), 64'd1);
    nextCycle();
    setInputs(1'b0, 64'h0, 1'b0, 8'h00, 1'b0, 64'h0);
    @(negedge clk);
    checkOutput("rst-mid busy mem_valid", 64'(memValid), 64'd1);
    checkOutput("rst-mid busy mem_is_write", 64'(memIsWrite), 64'd1);
    #2;
    reset = 1'b0;
    setInputs(1'b1, A_I, 1'b0, 8'h00, 1'b1, R2);
    #1;
    checkOutput("rst-mid mem_valid", 64'(memValid), 64'd0);
    checkOutput("rst-mid mem_is_write", 64'(memIsWrite), 64'd0);
    checkOutput("rst-mid mem_addr", memAddr, 64'h0);
    checkOutput("rst-mid mem_strobe", 64'(memStrobe), 64'd0);
    checkOutput("rst-mid mem_wdata", memWdata, 64'h0);
    checkOutput("rst-mid mem_size", 64'(memSize), 64'd0);
    checkOutput("rst-mid dresp_data_ok", 64'(dDataOk), 64'd0);
    checkOutput("rst-mid dresp_data", dData, 64'h0);
    checkOutput("rst-mid iresp_addr_ok", 64'(iAddrOk), 64'd0);
    nextCycle();
    reset = 1'b1;
    setInputs(1'b1, A_I, 1'b0, 8'h00, 1'b0, 64'h0);
    @(negedge clk);
    checkOutput("post-rst iresp_addr_ok", 64'(iAddrOk), 64'd1);
    checkOutput("post-rst mem_valid", 64'(memValid), 64'd0);
    nextCycle();
    setInputs(1'b0, 64'h0, 1'b0, 8'h00, 1'b1, R1);
    @(negedge clk);
    checkOutput("post-rst mem_valid", 64'(memValid), 64'd1);
    checkOutput("post-rst mem_addr", memAddr, A_I);
    checkOutput("post-rst iresp_data_ok", 64'(iDataOk), 64'd1);
    checkOutput("post-rst iresp_data", 64'(iData), 64'h1111_2222);
    nextCycle();
    setInputs(1'b0, 64'h0, 1'b0, 8'h00, 1'b0, 64'h0);
    @(negedge clk);
    checkOutput("final mem_valid", 64'(memValid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
